// File: rtl/clk_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_meas_pkg
// Description : Shared types and constants for the clk50-domain period and
//               duty-cycle meter.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_meas_pkg;

   // Default width of every count output
   localparam int c_cnt_w_default = 32;

   // Measurement FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_meas_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Two-flop synchronizer for an asynchronous input followed by a
//               one-flop edge detector with registered rise/fall strobes.
//               Input-to-strobe latency is three clk50 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge (
   input  logic clk50,
   input  logic rst,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_rise;
   logic r_fall;

   // Synchronize, keep the previous synchronized level, register the strobes
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_meta <= i_sig;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_rise <= r_sync & ~r_prev;
         r_fall <= ~r_sync & r_prev;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/clk_meas.sv
`default_nettype none
// ============================================================================
// Module      : clk_meas
// Description : Measures period and high time of a slow asynchronous signal
//               in clk50 cycles, with sticky per-phase timeout and lock flag.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_meas
   import clk_meas_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int CNT_W          = c_cnt_w_default
) (
   input  logic             clk50,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             enable,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             timeout,
   output logic             locked
);

   localparam logic [CNT_W-1:0] c_tmo = CNT_W'(TIMEOUT_CYCLES);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_high_lat;
   logic [CNT_W:0]   w_sum;
   logic             w_rise;
   logic             w_fall;
   logic             w_cnt_at_tmo;
   logic             w_edge_go;
   logic             w_tmo_hit;
   logic             w_meas;
   logic             w_latch;

   sync_edge u_sync_edge (
      .clk50  (clk50),
      .rst    (rst),
      .i_sig  (sig_in),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   assign w_cnt_at_tmo = (r_cnt == c_tmo);
   // One extra bit so a huge period saturates instead of wrapping
   assign w_sum        = {1'b0, r_high_lat} + {1'b0, r_cnt};

   // State register
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state: disable overrides everything, a handled edge beats timeout
   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: w_state_nxt = ARM;
            ARM: begin
               if (w_rise)            w_state_nxt = HIGH;
               else if (w_cnt_at_tmo) w_state_nxt = ARM;
            end
            HIGH: begin
               if (w_fall)            w_state_nxt = LOW;
               else if (w_cnt_at_tmo) w_state_nxt = ARM;
            end
            LOW: begin
               if (w_rise)            w_state_nxt = HIGH;
               else if (w_cnt_at_tmo) w_state_nxt = ARM;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Decoded control strobes for the datapath
   always_comb begin
      w_meas    = enable && (r_state == LOW)  && w_rise;
      w_latch   = enable && (r_state == HIGH) && w_fall;
      w_edge_go = enable && (((r_state == ARM)  && w_rise) ||
                             ((r_state == HIGH) && w_fall) ||
                             ((r_state == LOW)  && w_rise));
      w_tmo_hit = enable && (r_state != IDLE) && !w_edge_go && w_cnt_at_tmo;
   end

   // Phase counter: restarts at 1 on each accepted edge, never wraps
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!enable || (r_state == IDLE)) begin
         r_cnt <= '0;
      end else if (w_edge_go) begin
         r_cnt <= CNT_W'(1);
      end else if (w_tmo_hit) begin
         r_cnt <= '0;
      end else if (r_cnt != '1) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Latch high-phase length and publish results on the closing rise
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         r_high_lat <= '0;
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
      end else begin
         meas_valid <= w_meas;
         if (w_latch) r_high_lat <= r_cnt;
         if (w_meas) begin
            period    <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
            high_time <= r_high_lat;
         end
      end
   end

   // Sticky timeout and lock status
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         timeout <= 1'b0;
         locked  <= 1'b0;
      end else if (!enable) begin
         timeout <= 1'b0;
         locked  <= 1'b0;
      end else if (w_meas) begin
         timeout <= 1'b0;
         locked  <= 1'b1;
      end else if (w_tmo_hit) begin
         timeout <= 1'b1;
         locked  <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_clk_meas.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_meas
// Description : Directed self-checking bench for clk_meas (TIMEOUT_CYCLES=100).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_meas;
   import clk_meas_pkg::*;

   logic        clk50 = 1'b0;
   logic        rst;
   logic        sig_in;
   logic        enable;
   logic [31:0] period;
   logic [31:0] high_time;
   logic        meas_valid;
   logic        timeout;
   logic        locked;

   int n_checks = 0;
   int n_errors = 0;

   // Monitor state (written only by the monitor process)
   int          cyc = 0;
   int          mv_cnt = 0;
   int          last_mv_cyc = 0;
   int          last_gap = 0;
   int          stab_viol = 0;
   logic [31:0] last_p = '0;
   logic [31:0] last_h = '0;
   logic [31:0] prev_p = '0;
   logic [31:0] prev_h = '0;
   logic        skip_stab = 1'b1;

   clk_meas #(.TIMEOUT_CYCLES(100), .CNT_W(32)) dut (
      .clk50      (clk50),
      .rst        (rst),
      .sig_in     (sig_in),
      .enable     (enable),
      .period     (period),
      .high_time  (high_time),
      .meas_valid (meas_valid),
      .timeout    (timeout),
      .locked     (locked)
   );

   always #10 clk50 = ~clk50;

   // Capture result strobes and watch that results only move with meas_valid
   always @(negedge clk50) begin
      cyc = cyc + 1;
      if (meas_valid) begin
         mv_cnt      = mv_cnt + 1;
         last_p      = period;
         last_h      = high_time;
         last_gap    = cyc - last_mv_cyc;
         last_mv_cyc = cyc;
      end
      if (!skip_stab && !meas_valid && (period !== prev_p || high_time !== prev_h))
         stab_viol = stab_viol + 1;
      prev_p = period;
      prev_h = high_time;
   end

   // Hold sig_in at lvl for n clock cycles; returns 1 ns after a posedge
   task automatic phase(input logic lvl, input int n);
      sig_in = lvl;
      repeat (n) @(posedge clk50);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; sig_in = 1'b0;
      repeat (3) @(posedge clk50);
      #1;
      n_checks = n_checks + 1;
      if ({period, high_time, meas_valid, timeout, locked} !== 67'd0) begin
         n_errors = n_errors + 1;
         $display("FAIL reset_outputs: got p=%0d h=%0d mv=%b to=%b lk=%b expected all 0",
                  period, high_time, meas_valid, timeout, locked);
      end
      n_checks = n_checks + 1;
      if (dut.r_state !== IDLE) begin
         n_errors = n_errors + 1;
         $display("FAIL reset_state: got %0d expected %0d", dut.r_state, IDLE);
      end
      rst = 1'b0;
      phase(1'b0, 2);
      skip_stab = 1'b0;
   endtask

   task automatic test_square();
      int mv0;
      enable = 1'b1;
      phase(1'b0, 10);
      mv0 = mv_cnt;
      for (int i = 0; i < 4; i++) begin
         phase(1'b1, 25);
         phase(1'b0, 25);
      end
      phase(1'b1, 5);
      chk("square_mv_count", 32'(mv_cnt - mv0), 32'd4);
      chk("square_period", last_p, 32'd50);
      chk("square_high", last_h, 32'd25);
      chk("square_gap", 32'(last_gap), 32'd50);
      chk("square_locked", {31'd0, locked}, 32'd1);
      chk("square_timeout", {31'd0, timeout}, 32'd0);
   endtask

   task automatic test_duty();
      int mv0;
      mv0 = mv_cnt;
      phase(1'b1, 20);
      phase(1'b0, 25);
      phase(1'b1, 10);
      phase(1'b0, 40);
      phase(1'b1, 5);
      chk("duty_mv_count", 32'(mv_cnt - mv0), 32'd2);
      chk("duty_period", last_p, 32'd50);
      chk("duty_high", last_h, 32'd10);
   endtask

   task automatic test_timeout();
      int mv0;
      mv0 = mv_cnt;
      phase(1'b1, 98);
      chk("tmo_before_limit", {31'd0, timeout}, 32'd0);
      phase(1'b1, 1);
      chk("tmo_at_limit", {31'd0, timeout}, 32'd1);
      chk("tmo_locked", {31'd0, locked}, 32'd0);
      chk("tmo_state", {30'd0, dut.r_state}, {30'd0, ARM});
      chk("tmo_no_meas", 32'(mv_cnt - mv0), 32'd0);
      phase(1'b1, 40);
      chk("tmo_sticky", {31'd0, timeout}, 32'd1);
      phase(1'b0, 25);
      phase(1'b1, 25);
      phase(1'b0, 25);
      chk("tmo_held_until_meas", {31'd0, timeout}, 32'd1);
      phase(1'b1, 5);
      chk("tmo_cleared", {31'd0, timeout}, 32'd0);
      chk("tmo_relocked", {31'd0, locked}, 32'd1);
      chk("tmo_resume_period", last_p, 32'd50);
      chk("tmo_resume_high", last_h, 32'd25);
   endtask

   task automatic test_edge_beats_timeout();
      int mv0;
      mv0 = mv_cnt;
      phase(1'b1, 20);
      phase(1'b0, 100);
      phase(1'b1, 5);
      chk("edge_tmo_mv_count", 32'(mv_cnt - mv0), 32'd1);
      chk("edge_tmo_period", last_p, 32'd125);
      chk("edge_tmo_high", last_h, 32'd25);
      chk("edge_tmo_timeout", {31'd0, timeout}, 32'd0);
   endtask

   task automatic test_enable_drop();
      int mv0;
      phase(1'b1, 5);
      mv0 = mv_cnt;
      enable = 1'b0;
      @(posedge clk50);
      #1;
      chk("endrop_state", {30'd0, dut.r_state}, {30'd0, IDLE});
      chk("endrop_locked", {31'd0, locked}, 32'd0);
      chk("endrop_timeout", {31'd0, timeout}, 32'd0);
      phase(1'b0, 25);
      phase(1'b1, 25);
      phase(1'b0, 25);
      phase(1'b1, 5);
      chk("endrop_no_meas", 32'(mv_cnt - mv0), 32'd0);
      chk("endrop_period_hold", period, 32'd125);
      chk("endrop_high_hold", high_time, 32'd25);
   endtask

   task automatic test_async_reset();
      int mv0;
      enable = 1'b1;
      phase(1'b0, 10);
      phase(1'b1, 25);
      phase(1'b0, 10);
      chk("arst_not_locked_yet", {31'd0, locked}, 32'd0);
      skip_stab = 1'b1;
      #5 rst = 1'b1;
      #2;
      n_checks = n_checks + 1;
      if ({period, high_time, meas_valid, timeout, locked} !== 67'd0) begin
         n_errors = n_errors + 1;
         $display("FAIL arst_outputs: got p=%0d h=%0d mv=%b to=%b lk=%b expected all 0",
                  period, high_time, meas_valid, timeout, locked);
      end
      chk("arst_state", {30'd0, dut.r_state}, {30'd0, IDLE});
      #1 rst = 1'b0;
      @(posedge clk50);
      #1;
      skip_stab = 1'b0;
      mv0 = mv_cnt;
      phase(1'b0, 15);
      phase(1'b1, 25);
      phase(1'b0, 25);
      chk("arst_no_early_meas", 32'(mv_cnt - mv0), 32'd0);
      phase(1'b1, 5);
      chk("arst_first_meas", 32'(mv_cnt - mv0), 32'd1);
      chk("arst_period", last_p, 32'd50);
      chk("arst_high", last_h, 32'd25);
   endtask

   task automatic test_stability();
      chk("result_stability", 32'(stab_viol), 32'd0);
   endtask

   initial begin
      test_reset();
      test_square();
      test_duty();
      test_timeout();
      test_edge_beats_timeout();
      test_enable_drop();
      test_async_reset();
      test_stability();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
